vdcdiv_64by32: RTL and testbench

VDCDIV_64BY32 -- requirements
Module: vdcdiv_64by32

---
 rtl/vdcdiv_64by32_pkg.sv | 15 +
 rtl/vdcdiv_64by32_rca32b.sv | 22 ++
 rtl/vdcdiv_64by32.sv | 120 ++++++++++++
 tb/tb_vdcdiv_64by32.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vdcdiv_64by32_pkg.sv
// Shared definitions for the 64/32 restoring divider: FSM states and datapath widths.
package vdcdiv_64by32_pkg;

  localparam int unsigned DVD_W    = 64;
  localparam int unsigned DVS_W    = 32;
  localparam int unsigned PR_W     = 33;
  localparam int unsigned ITER_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/vdcdiv_64by32_rca32b.sv
// 32-bit ripple-carry adder; used by the divider as its trial subtractor.
module rca32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic c;

  always_comb begin
    c   = cin;
    sum = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/vdcdiv_64by32.sv
// 64-by-32 unsigned radix-2 restoring divider, one quotient bit per clock, MSB first.
module vdcdiv_64by32
  import vdcdiv_64by32_pkg::*;
#(
  parameter int unsigned ITER = ITER_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DVD_W-1:0]     dividend,
  input  logic [DVS_W-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [DVS_W-1:0]     quotient,
  output logic [DVS_W-1:0]     remainder,
  output logic                 dz,
  output logic                 ovf
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  div_state_t        state, nxt;
  logic [CW-1:0]     cnt;
  logic [PR_W-1:0]   pr;
  logic [DVS_W-1:0]  sr;
  logic [DVS_W-1:0]  dvs;

  logic              in_dz, in_ovf, in_exc;
  logic              last;
  logic [PR_W:0]     shifted;
  logic [DVS_W-1:0]  diff;
  logic              cout;
  logic              nonneg;
  logic [DVS_W-1:0]  q_next;

  assign in_dz  = (divisor == '0);
  assign in_ovf = (dividend[DVD_W-1:DVS_W] >= divisor);
  assign in_exc = in_dz | in_ovf;
  assign last   = (cnt == CW'(ITER - 1));

  // sr doubles as dividend-low source (MSB out) and quotient collector (LSB in)
  assign shifted = {pr, sr[DVS_W-1]};

  rca32b u_sub (
    .a    (shifted[DVS_W-1:0]),
    .b    (~dvs),
    .cin  (1'b1),
    .sum  (diff),
    .cout (cout)
  );

  assign nonneg = (|shifted[PR_W:DVS_W]) | cout;
  assign q_next = {sr[DVS_W-2:0], nonneg};

  assign busy = (state == S_CALC);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) nxt = in_exc ? S_DONE : S_CALC;
        else       nxt = S_IDLE;
      end
      S_CALC:  if (last) nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      pr        <= '0;
      sr        <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pr  <= {1'b0, dividend[DVD_W-1:DVS_W]};
            sr  <= dividend[DVS_W-1:0];
            dvs <= divisor;
            cnt <= '0;
            dz  <= 1'b0;
            ovf <= 1'b0;
            if (in_dz) begin
              dz        <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[DVS_W-1:0];
            end else if (in_ovf) begin
              ovf       <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
            end
          end
        end
        S_CALC: begin
          pr  <= nonneg ? {1'b0, diff} : shifted[PR_W-1:0];
          sr  <= q_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            quotient  <= q_next;
            remainder <= nonneg ? diff : shifted[DVS_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vdcdiv_64by32.sv
// Self-checking bench for vdcdiv_64by32: directed corners plus randomized back-to-back divides.
module tb_vdcdiv_64by32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        busy, done, dz, ovf;
  logic [31:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;
  longint cyc  = 0;

  vdcdiv_64by32 #(.ITER(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [63:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic z, output logic o);
    if (b == 32'd0) begin
      q = '1; r = a[31:0]; z = 1'b1; o = 1'b0;
    end else if (a[63:32] >= b) begin
      q = '1; r = '0; z = 1'b0; o = 1'b1;
    end else begin
      q = 32'(a / {32'd0, b});
      r = 32'(a % {32'd0, b});
      z = 1'b0; o = 1'b0;
    end
  endfunction

  task automatic launch(input logic [63:0] a, input logic [31:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the accept edge; k counts edges until done is seen.
  task automatic wait_done(output int k, output int nbusy);
    k = 0;
    nbusy = 0;
    while (!done && k < 40) begin
      if (busy) nbusy++;
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic check_result(input string tag, input logic [63:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    logic ez, eo;
    model(a, b, eq, er, ez, eo);
    check({tag, " done"}, {63'd0, done}, 64'd1);
    check({tag, " q"}, {32'd0, quotient}, {32'd0, eq});
    check({tag, " r"}, {32'd0, remainder}, {32'd0, er});
    check({tag, " dz"}, {63'd0, dz}, {63'd0, ez});
    check({tag, " ovf"}, {63'd0, ovf}, {63'd0, eo});
    if (!ez && !eo)
      check({tag, " roundtrip"}, {32'd0, quotient} * {32'd0, b} + {32'd0, remainder}, a);
  endtask

  task automatic do_op(input string tag, input logic [63:0] a, input logic [31:0] b);
    int k, nb;
    logic exc;
    exc = (b == 32'd0) || (a[63:32] >= b);
    launch(a, b);
    wait_done(k, nb);
    check({tag, " latency"}, 64'(k), exc ? 64'd0 : 64'd32);
    check({tag, " busycycles"}, 64'(nb), exc ? 64'd0 : 64'd32);
    check_result(tag, a, b);
    @(posedge clk);
    #1;
    check({tag, " pulse"}, {63'd0, done}, 64'd0);
  endtask

  function automatic void rand_op(output logic [63:0] a, output logic [31:0] b, input int sel);
    logic [31:0] hi;
    if (sel % 4 == 0) begin
      b  = 32'($urandom_range(1, 255));
      hi = '0;
    end else begin
      b = $urandom;
      if (b == 32'd0) b = 32'd1;
      hi = $urandom % b;
    end
    a = {hi, 32'($urandom)};
  endfunction

  initial begin
    logic [63:0] a, na;
    logic [31:0] b, nb32;
    int k, nb, nd;
    longint last_done;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst q", {32'd0, quotient}, 64'd0);
    check("rst r", {32'd0, remainder}, 64'd0);
    check("rst flags", {62'd0, dz, ovf}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("basic", 64'd100, 32'd7);
    check("basic q const", {32'd0, quotient}, 64'd14);
    check("basic r const", {32'd0, remainder}, 64'd2);
    do_op("max", 64'hFFFFFFFE_00000001, 32'hFFFFFFFF);
    check("max q const", {32'd0, quotient}, 64'hFFFFFFFF);
    do_op("dz", 64'h12345678_9ABCDEF0, 32'd0);
    check("dz r const", {32'd0, remainder}, 64'h9ABCDEF0);
    do_op("ovf", 64'h1_00000000, 32'd1);
    do_op("ovf eq", 64'h00000005_00000000, 32'd5);
    do_op("small", 64'h00000004_FFFFFFFF, 32'd5);

    // Reset in the middle of an operation.
    launch(64'h00000003_12345678, 32'h10001);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort done", {63'd0, done}, 64'd0);
    check("abort q", {32'd0, quotient}, 64'd0);
    check("abort r", {32'd0, remainder}, 64'd0);
    check("abort flags", {62'd0, dz, ovf}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) nd++;
    end
    check("abort quiet", 64'(nd), 64'd0);

    // Start while busy must not disturb the running operation.
    launch(64'h00000007_89ABCDEF, 32'h0123_4567);
    repeat (4) @(posedge clk);
    @(negedge clk);
    dividend = 64'h00000001_00000000;
    divisor  = 32'd0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignore busy", {63'd0, busy}, 64'd1);
    wait_done(k, nb);
    check("ignore latency", 64'(k), 64'd27);
    check_result("ignore", 64'h00000007_89ABCDEF, 32'h0123_4567);
    @(posedge clk);
    #1;

    // Randomized exceptions mixed with valid operands, one at a time.
    for (int i = 0; i < 16; i++) begin
      rand_op(a, b, i);
      if (i % 4 == 1) b = 32'd0;
      if (i % 4 == 2) a[63:32] = b + 32'($urandom_range(0, 3));
      if (a[63:32] < b && i % 4 == 2) a[63:32] = '1;
      do_op("rand single", a, b);
    end

    // Back-to-back: start held high, new operands loaded in each done cycle.
    rand_op(a, b, 1);
    last_done = 0;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 1000; i++) begin
      wait_done(k, nb);
      if (i == 0) check("b2b first latency", 64'(k), 64'd32);
      else        check("b2b spacing", 64'(cyc - last_done), 64'd33);
      last_done = cyc;
      check_result("b2b", a, b);
      if (!done) begin
        $display("FAIL b2b timeout: got no done expected done");
        n_fail++;
        break;
      end
      rand_op(na, nb32, i);
      a = na; b = nb32;
      dividend = a; divisor = b;
      if (i == 999) start = 1'b0;
      @(posedge clk);
      #1;
    end
    check("b2b idle", {62'd0, busy, done}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
